// File: rtl/icache_loader.sv
// icache_loader: packs a 16-bit word stream into 60-bit instructions and writes them to consecutive
// icache addresses while holding the core halted. Define ICACHE_LOADER_TAGCHK_EN to require word0[15:12] == 4'hA.
module icache_loader #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 60,
    parameter int WORD_W  = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [ADDR_W-1:0]  baseAddr_i,
    input  logic [ADDR_W-1:0]  count_i,
    input  logic               wordValid_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic               wordReady_o,
    output logic               halt_o,
    output logic               icacheWriteEnable_o,
    output logic [ADDR_W-1:0]  writeAddress_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    // Word0 contributes only its low bits; the rest of the instruction is three full words.
    localparam int LANE0_W = INSTR_W - 3 * WORD_W;

    logic [2:0]              stateReg, stateNext;
    logic [ADDR_W-1:0]       baseReg, countReg, indexReg;
    logic [1:0]              wordCntReg;
    logic [INSTR_W-1:WORD_W] asmReg;
    logic [ADDR_W-1:0]       addrReg;
    logic [INSTR_W-1:0]      instrReg;
    logic                    wordAccept, lastWord, lastInstr, tagBad;

    assign wordAccept = (stateReg == FILL) && wordValid_i && !abort_i;
    assign lastWord   = wordAccept && (wordCntReg == 2'd3);
    assign lastInstr  = (indexReg == countReg - ADDR_ONE);

`ifdef ICACHE_LOADER_TAGCHK_EN
    logic errorReg;
    assign tagBad  = wordAccept && (wordCntReg == 2'd0) && (word_i[WORD_W-1:LANE0_W] != 4'hA);
    assign error_o = errorReg;
`else
    logic unusedTagBits;
    assign unusedTagBits = ^word_i[WORD_W-1:LANE0_W];
    assign tagBad  = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start_i) stateNext = (count_i != '0) ? FILL : DONE;
            FILL: begin
                if (abort_i)       stateNext = IDLE;
                else if (tagBad)   stateNext = ERROR;
                else if (lastWord) stateNext = WRITE;
            end
            WRITE: begin
                if (abort_i)        stateNext = IDLE;
                else if (lastInstr) stateNext = DONE;
                else                stateNext = FILL;
            end
            DONE:    stateNext = IDLE;
            ERROR:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            stateReg   <= IDLE;
            baseReg    <= '0;
            countReg   <= '0;
            indexReg   <= '0;
            wordCntReg <= '0;
            asmReg     <= '0;
            addrReg    <= '0;
            instrReg   <= '0;
`ifdef ICACHE_LOADER_TAGCHK_EN
            errorReg   <= 1'b0;
`endif
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    if (start_i) begin
                        baseReg    <= baseAddr_i;
                        countReg   <= count_i;
                        indexReg   <= '0;
                        wordCntReg <= '0;
`ifdef ICACHE_LOADER_TAGCHK_EN
                        errorReg   <= 1'b0;
`endif
                    end
                end
                FILL: begin
                    if (wordAccept) begin
                        wordCntReg <= wordCntReg + 2'd1;
                        case (wordCntReg)
                            2'd0: asmReg[INSTR_W-1:3*WORD_W]  <= word_i[LANE0_W-1:0];
                            2'd1: asmReg[3*WORD_W-1:2*WORD_W] <= word_i;
                            2'd2: asmReg[2*WORD_W-1:WORD_W]   <= word_i;
                            2'd3: begin
                                // Output registers load only on a complete instruction so they hold between writes.
                                instrReg <= {asmReg, word_i};
                                addrReg  <= baseReg + indexReg;
                            end
                        endcase
                    end
`ifdef ICACHE_LOADER_TAGCHK_EN
                    if (tagBad) errorReg <= 1'b1;
`endif
                end
                WRITE: indexReg <= indexReg + ADDR_ONE;
                default: ;
            endcase
        end
    end

    assign wordReady_o         = (stateReg == FILL);
    assign halt_o              = (stateReg == FILL) || (stateReg == WRITE);
    assign busy_o              = (stateReg == FILL) || (stateReg == WRITE);
    assign icacheWriteEnable_o = (stateReg == WRITE);
    assign done_o              = (stateReg == DONE);
    assign writeAddress_o      = addrReg;
    assign instruction_o       = instrReg;
endmodule
